// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Fetch control FSM for the lab CPU. Owns the program counter,
//            handshakes with instruction memory, applies redirects
//            (halt > branch > jump) and hazard stalls in fixed priority,
//            and keeps saturating cycle / retired-instruction counters.
// Ports    : clock, reset_n      - clock, synchronous active-low reset
//            start               - begin at address 0 (IDLE/HALT only)
//            stall               - hold pc, accept nothing
//            branch_taken/off    - PC-relative redirect
//            jump_req/target     - absolute redirect
//            done                - halt instruction decoded
//            imem_ready          - memory data for address pc available
//            pc, imem_req        - fetch address / request (Moore)
//            instr_valid,fetch_pc- accept pulse and its address (Mealy)
//            halted              - FSM in HALT
//            cycle_count         - FETCH+FLUSH cycles, saturating
//            retired_count       - accepted instructions, saturating
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 17
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_off,
    input  logic             jump_req,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             done,
    input  logic             imem_ready,
    output logic [PC_W-1:0]  pc,
    output logic             imem_req,
    output logic             instr_valid,
    output logic [PC_W-1:0]  fetch_pc,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_halt  = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_fetch_pc;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_retired_count;

    logic [1:0]       w_state_nxt;
    logic [PC_W-1:0]  w_pc_nxt;
    logic             w_in_fetch;
    logic             w_active;
    logic             w_start;
    logic             w_accept;

    assign w_in_fetch = (r_state == c_st_fetch);
    assign w_active   = w_in_fetch || (r_state == c_st_flush);
    assign w_start    = start && ((r_state == c_st_idle) || (r_state == c_st_halt));

    // An instruction arriving alongside any redirect or stall is wrong-path
    // or must be replayed, so it is dropped rather than accepted.
    assign w_accept = w_in_fetch && imem_ready && !stall && !done
                      && !branch_taken && !jump_req;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            c_st_idle, c_st_halt: begin
                if (start) begin
                    w_state_nxt = c_st_fetch;
                    w_pc_nxt    = '0;
                end
            end
            c_st_fetch: begin
                if (done) begin
                    w_state_nxt = c_st_halt;
                end else if (branch_taken) begin
                    // Natural PC_W-bit wrap gives modulo-2^PC_W arithmetic.
                    w_pc_nxt    = r_pc + branch_off;
                    w_state_nxt = c_st_flush;
                end else if (jump_req) begin
                    w_pc_nxt    = jump_target;
                    w_state_nxt = c_st_flush;
                end else if (stall) begin
                    w_pc_nxt    = r_pc;
                end else if (imem_ready) begin
                    w_pc_nxt    = r_pc + PC_W'(1);
                end
            end
            c_st_flush: begin
                // Single bubble; every input is ignored here.
                w_state_nxt = c_st_fetch;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state         <= c_st_idle;
            r_pc            <= '0;
            r_fetch_pc      <= '0;
            r_cycle_count   <= '0;
            r_retired_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_accept) begin
                r_fetch_pc <= r_pc;
            end
            if (w_start) begin
                r_cycle_count   <= '0;
                r_retired_count <= '0;
            end else begin
                if (w_active && (r_cycle_count != c_cnt_max)) begin
                    r_cycle_count <= r_cycle_count + CNT_W'(1);
                end
                if (w_accept && (r_retired_count != c_cnt_max)) begin
                    r_retired_count <= r_retired_count + CNT_W'(1);
                end
            end
        end
    end

    assign pc            = r_pc;
    assign imem_req      = w_in_fetch;
    assign halted        = (r_state == c_st_halt);
    assign instr_valid   = w_accept;
    // During the accept pulse the address is the current pc; afterwards the
    // registered copy keeps presenting the last accepted address.
    assign fetch_pc      = w_accept ? r_pc : r_fetch_pc;
    assign cycle_count   = r_cycle_count;
    assign retired_count = r_retired_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. Accepted-instruction
//            addresses are predicted into a scoreboard queue as stimulus is
//            driven and compared whenever the DUT pulses instr_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int PC_W  = 8;
    localparam int CNT_W = 17;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             stall;
    logic             branch_taken;
    logic [PC_W-1:0]  branch_off;
    logic             jump_req;
    logic [PC_W-1:0]  jump_target;
    logic             done;
    logic             imem_ready;
    logic [PC_W-1:0]  pc;
    logic             imem_req;
    logic             instr_valid;
    logic [PC_W-1:0]  fetch_pc;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;

    logic [PC_W-1:0]  w_pc4;
    logic             w_imem_req4;
    logic             w_instr_valid4;
    logic [PC_W-1:0]  w_fetch_pc4;
    logic             w_halted4;
    logic [3:0]       w_cycle_count4;
    logic [3:0]       w_retired_count4;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cyc  = 0;
    int exp_ret  = 0;
    bit busy     = 0;
    logic [PC_W-1:0] sb[$];

    fetch_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_off(branch_off),
        .jump_req(jump_req), .jump_target(jump_target), .done(done),
        .imem_ready(imem_ready), .pc(pc), .imem_req(imem_req),
        .instr_valid(instr_valid), .fetch_pc(fetch_pc), .halted(halted),
        .cycle_count(cycle_count), .retired_count(retired_count)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    fetch_sequencer #(.PC_W(PC_W), .CNT_W(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_off(branch_off),
        .jump_req(jump_req), .jump_target(jump_target), .done(done),
        .imem_ready(imem_ready), .pc(w_pc4), .imem_req(w_imem_req4),
        .instr_valid(w_instr_valid4), .fetch_pc(w_fetch_pc4), .halted(w_halted4),
        .cycle_count(w_cycle_count4), .retired_count(w_retired_count4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock; the cycle just ended counts toward cycle_count if busy.
    task automatic step();
        if (busy) exp_cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_accept(input logic [PC_W-1:0] addr);
        sb.push_back(addr);
        exp_ret++;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cyc"}, 32'(cycle_count), exp_cyc);
        check({tag, "_ret"}, 32'(retired_count), exp_ret);
    endtask

    // Scoreboard consumer: every accept pulse must match a predicted address.
    always @(negedge clock) begin
        if (reset_n && instr_valid) begin
            if (sb.size() == 0) check("sb_unexpected_accept", 32'(sb.size()), 1);
            else                check("sb_fetch_pc", 32'(fetch_pc), 32'(sb.pop_front()));
        end
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_off = '0; jump_req = 1'b0; jump_target = '0; done = 1'b0;
        imem_ready = 1'b0;
        step(); step();
        check("rst_pc", 32'(pc), 0);
        check("rst_fetch_pc", 32'(fetch_pc), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check_counters("rst");
        reset_n = 1'b1;

        // ---- Sequential run -------------------------------------------------
        start = 1'b1; step(); start = 1'b0; busy = 1; exp_cyc = 0; exp_ret = 0;
        check("seq_first_req", 32'(imem_req), 1);
        check("seq_first_pc", 32'(pc), 0);
        imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_accept(PC_W'(i));
            step();
        end
        imem_ready = 1'b0;
        #1;
        check("seq_pc", 32'(pc), 5);
        check("seq_fetch_pc_hold", 32'(fetch_pc), 4);
        check_counters("seq");

        // ---- Branch with wrap (reach pc=250 through a jump) -----------------
        jump_req = 1'b1; jump_target = 8'd250; step(); jump_req = 1'b0;
        check("jmp250_flush_req", 32'(imem_req), 0);
        step();
        check("jmp250_pc", 32'(pc), 250);
        branch_taken = 1'b1; branch_off = 8'h0A; imem_ready = 1'b1;
        #1;
        check("br_no_accept", 32'(instr_valid), 0);
        step(); branch_taken = 1'b0;
        #1;
        check("br_pc_wrap", 32'(pc), 4);
        check("br_flush_req", 32'(imem_req), 0);
        check("br_flush_valid", 32'(instr_valid), 0);
        step();
        check("br_target_req", 32'(imem_req), 1);
        check("br_target_pc", 32'(pc), 4);
        expect_accept(8'd4); step();

        // ---- Priority at pc=7 ------------------------------------------------
        expect_accept(8'd5); step();
        expect_accept(8'd6); step();
        check("pri_pc_pre", 32'(pc), 7);
        done = 1'b1; branch_taken = 1'b1; jump_req = 1'b1; stall = 1'b1;
        branch_off = 8'h10; jump_target = 8'h80;
        #1;
        check("pri_no_accept", 32'(instr_valid), 0);
        step(); busy = 0;
        done = 1'b0; branch_taken = 1'b0; jump_req = 1'b0; stall = 1'b0;
        check("pri_halted", 32'(halted), 1);
        check("pri_halt_req", 32'(imem_req), 0);
        check("pri_pc", 32'(pc), 7);
        check_counters("pri");
        for (int i = 0; i < 3; i++) step();
        check("halt_pc_frozen", 32'(pc), 7);
        check_counters("halt_frozen");
        start = 1'b1; step(); start = 1'b0; busy = 1; exp_cyc = 0; exp_ret = 0;
        check("restart_pc", 32'(pc), 0);
        check("restart_halted", 32'(halted), 0);
        check_counters("restart");

        // ---- Stall vs. jump ------------------------------------------------
        for (int i = 0; i < 3; i++) begin
            expect_accept(PC_W'(i));
            step();
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_no_accept", 32'(instr_valid), 0);
            step();
            check("stall_pc_held", 32'(pc), 3);
        end
        jump_req = 1'b1; jump_target = 8'h40;
        step(); jump_req = 1'b0; stall = 1'b0;
        check("jmp_pc", 32'(pc), 32'h40);
        check("jmp_flush_req", 32'(imem_req), 0);

        // ---- Reset mid-run during FLUSH ------------------------------------
        reset_n = 1'b0; start = 1'b1;
        step(); busy = 0; exp_cyc = 0; exp_ret = 0;
        reset_n = 1'b1; start = 1'b0;
        check("mrst_pc", 32'(pc), 0);
        check("mrst_req", 32'(imem_req), 0);
        check("mrst_fetch_pc", 32'(fetch_pc), 0);
        check_counters("mrst");
        step();
        check("mrst_idle_req", 32'(imem_req), 0);

        // ---- Saturation -----------------------------------------------------
        start = 1'b1; step(); start = 1'b0; busy = 1; exp_cyc = 0; exp_ret = 0;
        for (int i = 0; i < 20; i++) begin
            expect_accept(PC_W'(i));
            step();
        end
        imem_ready = 1'b0;
        #1;
        check("sat_pc", 32'(pc), 20);
        check_counters("sat_wide");
        check("sat4_cyc", 32'(w_cycle_count4), 15);
        check("sat4_ret", 32'(w_retired_count4), 15);

        step();
        check("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
